// File: rtl/modulo_divisor_programavel_pkg.sv
// Shared constants, divisor type and index-width helper for the programmable divider.
package divisor_pkg;

   localparam int DIV_W_DEF   = 20;
   localparam int N_CH_DEF    = 4;
   localparam int DIV_RST_DEF = 50000;

   typedef logic [DIV_W_DEF-1:0] div_t;

   // Channel index width; a single channel still needs a 1-bit select.
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/modulo_divisor_programavel_if.sv
// Control/status bundle of the programmable divider: enable, divisor write port, per-channel outputs.
interface modulo_divisor_programavel_if
   import divisor_pkg::*;
#(
   parameter int N_CH  = N_CH_DEF,
   parameter int DIV_W = DIV_W_DEF
);

   localparam int CH_W = ch_w(N_CH);

   logic              en;
   logic              wr_en;
   logic [CH_W-1:0]   wr_ch;
   logic [DIV_W-1:0]  wr_div;
   logic [N_CH-1:0]   pend;
   logic [N_CH-1:0]   tick;
   logic [N_CH-1:0]   sq;

   modport master (
      output en, wr_en, wr_ch, wr_div,
      input  pend, tick, sq
   );

   modport slave (
      input  en, wr_en, wr_ch, wr_div,
      output pend, tick, sq
   );

endinterface

// File: rtl/modulo_canal_divisor.sv
// One divider channel: down-counter with shadowed divisor reload and registered tick.
// Optional 50% duty square output built only when DIVISOR_DUTY50_EN is defined.
module modulo_canal_divisor
   import divisor_pkg::*;
#(
   parameter int DIV_W   = DIV_W_DEF,
   parameter int DIV_RST = DIV_RST_DEF
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic             wr,
   input  logic [DIV_W-1:0] wr_div,
   output logic             pend,
   output logic             tick,
   output logic             sq
);

   localparam logic [DIV_W-1:0] RST_ACT = DIV_W'(DIV_RST);
   localparam logic [DIV_W-1:0] RST_CNT = DIV_W'(DIV_RST - 1);

   logic [DIV_W-1:0] cnt, cnt_d;
   logic [DIV_W-1:0] active, active_d;
   logic [DIV_W-1:0] shadow, shadow_d;
   logic             pend_d, tick_d;
   logic             disabled, terminal;

   // Reload value for a divisor; a zero divisor parks the counter at 0.
   function automatic logic [DIV_W-1:0] reload(input logic [DIV_W-1:0] v);
      return (v == '0) ? '0 : v - 1'b1;
   endfunction

   assign disabled = (active == '0);
   assign terminal = !disabled && en && (cnt == '0);

   always_comb begin
      cnt_d    = cnt;
      active_d = active;
      shadow_d = wr ? wr_div : shadow;
      pend_d   = pend;
      tick_d   = 1'b0;
      if (disabled) begin
         if (wr) begin
            active_d = wr_div;
            cnt_d    = reload(wr_div);
         end
      end else if (terminal) begin
         // A write landing on the terminal cycle takes priority over the shadow.
         tick_d = 1'b1;
         pend_d = 1'b0;
         if (wr) begin
            active_d = wr_div;
            cnt_d    = reload(wr_div);
         end else if (pend) begin
            active_d = shadow;
            cnt_d    = reload(shadow);
         end else begin
            cnt_d = active - 1'b1;
         end
      end else begin
         if (en) cnt_d = cnt - 1'b1;
         if (wr) pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         cnt    <= RST_CNT;
         active <= RST_ACT;
         shadow <= RST_ACT;
         pend   <= 1'b0;
         tick   <= 1'b0;
      end else begin
         cnt    <= cnt_d;
         active <= active_d;
         shadow <= shadow_d;
         pend   <= pend_d;
         tick   <= tick_d;
      end
   end

`ifdef DIVISOR_DUTY50_EN
   // Toggles on the same edge that raises tick, so sq changes in the tick cycle.
   always_ff @(posedge clk or posedge clr) begin
      if (clr)           sq <= 1'b0;
      else if (terminal) sq <= ~sq;
   end
`else
   assign sq = 1'b0;
`endif

endmodule

// File: rtl/modulo_divisor_programavel.sv
// Multi-channel programmable tick divider: write decode plus N_CH independent channels.
// Define DIVISOR_DUTY50_EN to add per-channel 50% duty square outputs on sq.
module modulo_divisor_programavel
   import divisor_pkg::*;
#(
   parameter int N_CH    = N_CH_DEF,
   parameter int DIV_W   = DIV_W_DEF,
   parameter int DIV_RST = DIV_RST_DEF
) (
   input logic                          clk,
   input logic                          clr,
   modulo_divisor_programavel_if.slave  bus
);

   localparam int CH_W = ch_w(N_CH);

   logic [N_CH-1:0] wr_sel;
   logic [N_CH-1:0] pend_v;
   logic [N_CH-1:0] tick_v;
   logic [N_CH-1:0] sq_v;

   // Out-of-range channel indices match no bit and are dropped.
   always_comb begin
      wr_sel = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         wr_sel[i] = bus.wr_en && (bus.wr_ch == CH_W'(i));
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      modulo_canal_divisor #(
         .DIV_W   (DIV_W),
         .DIV_RST (DIV_RST)
      ) u_canal (
         .clk    (clk),
         .clr    (clr),
         .en     (bus.en),
         .wr     (wr_sel[i]),
         .wr_div (bus.wr_div),
         .pend   (pend_v[i]),
         .tick   (tick_v[i]),
         .sq     (sq_v[i])
      );
   end

   assign bus.pend = pend_v;
   assign bus.tick = tick_v;
   assign bus.sq   = sq_v;

endmodule

// File: tb/tb_modulo_divisor_programavel.sv
// Randomised and directed bench for the programmable divider against a period/remaining-cycles model.
module tb_modulo_divisor_programavel;
   import divisor_pkg::*;

   localparam int NCH  = 3;
   localparam int DW   = 10;
   localparam int DRST = 12;
   localparam int CW   = ch_w(NCH);
   localparam int LIM  = 64;

   logic clk = 1'b0;
   logic clr = 1'b1;
   always #5 clk = ~clk;

   modulo_divisor_programavel_if #(.N_CH(NCH), .DIV_W(DW)) bus ();

   modulo_divisor_programavel #(
      .N_CH    (NCH),
      .DIV_W   (DW),
      .DIV_RST (DRST)
   ) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   // Model: per = current period, rem = enabled cycles left before the next tick,
   // pv = last written value, pnd = a write is waiting for the period to end.
   int per [NCH];
   int rem [NCH];
   int pv  [NCH];
   bit pnd [NCH];
   bit tk  [NCH];
   bit sqm [NCH];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int c = 0; c < NCH; c++) begin
         per[c] = DRST; rem[c] = DRST; pv[c] = DRST;
         pnd[c] = 1'b0; tk[c] = 1'b0; sqm[c] = 1'b0;
      end
   endfunction

   function automatic void model_step(input bit e, input bit we, input int ch, input int dv);
      for (int c = 0; c < NCH; c++) begin
         bit w;
         w = we && (ch == c);
         tk[c] = 1'b0;
         if (per[c] == 0) begin
            if (w) begin per[c] = dv; rem[c] = dv; end
         end else if (e) begin
            rem[c]--;
            if (rem[c] == 0) begin
               int np;
               np = w ? dv : (pnd[c] ? pv[c] : per[c]);
               tk[c] = 1'b1; sqm[c] = ~sqm[c]; pnd[c] = 1'b0;
               per[c] = np; rem[c] = np;
            end else if (w) begin
               pnd[c] = 1'b1;
            end
         end else if (w) begin
            pnd[c] = 1'b1;
         end
         if (w) pv[c] = dv;
      end
   endfunction

   task automatic compare_all();
      for (int c = 0; c < NCH; c++) begin
         check($sformatf("tick%0d", c), 32'(bus.tick[c]), 32'(tk[c]));
         check($sformatf("pend%0d", c), 32'(bus.pend[c]), 32'(pnd[c]));
`ifdef DIVISOR_DUTY50_EN
         check($sformatf("sq%0d", c), 32'(bus.sq[c]), 32'(sqm[c]));
`else
         check($sformatf("sq%0d", c), 32'(bus.sq[c]), 32'd0);
`endif
      end
   endtask

   task automatic cyc(input bit e, input bit we, input int ch, input int dv);
      bus.en     = e;
      bus.wr_en  = we;
      bus.wr_ch  = CW'(ch);
      bus.wr_div = DW'(dv);
      @(posedge clk);
      model_step(e, we, ch, dv);
      #1;
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 0, 0);
   endtask

   task automatic wait_rem(input int c, input int r);
      int n;
      n = 0;
      while (rem[c] != r && n < LIM) begin
         cyc(1'b1, 1'b0, 0, 0);
         n++;
      end
      if (n == LIM) check("wait_rem_timeout", 32'(n), 32'd0);
   endtask

   task automatic wait_loaded(input int c);
      int n;
      n = 0;
      while (pnd[c] && n < LIM) begin
         cyc(1'b1, 1'b0, 0, 0);
         n++;
      end
      if (n == LIM) check("wait_load_timeout", 32'(n), 32'd0);
   endtask

   // Edges from the current one up to and including the edge that raises tick[c].
   task automatic gap_to_tick(input int c, output int n);
      n = 1;
      while (bus.tick[c] !== 1'b1 && n < LIM) begin
         cyc(1'b1, 1'b0, 0, 0);
         n++;
      end
   endtask

   task automatic async_reset();
      clr = 1'b1;
      #1;
      check("rst_tick", 32'(bus.tick), 32'd0);
      check("rst_pend", 32'(bus.pend), 32'd0);
      check("rst_sq",   32'(bus.sq),   32'd0);
      model_reset();
      #2;
      clr = 1'b0;
   endtask

   initial begin
      int n, hi;
      bus.en = 1'b0; bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_div = '0;
      model_reset();
      #2;
      check("rst_init_tick", 32'(bus.tick), 32'd0);
      check("rst_init_pend", 32'(bus.pend), 32'd0);
      #10;
      clr = 1'b0;

      // First tick exactly DRST edges after release.
      cyc(1'b1, 1'b0, 0, 0);
      gap_to_tick(0, n);
      check("first_tick_gap", 32'(n), 32'(DRST));
      idle(14);

      // Period 4 on ch0, period 1 on ch1.
      cyc(1'b1, 1'b1, 0, 4);
      check("pend0_after_wr", 32'(bus.pend[0]), 32'd1);
      wait_loaded(0);
      idle(10);
      cyc(1'b1, 1'b1, 1, 1);
      wait_loaded(1);
      idle(6);

      // Mid-count reprogram: period 10, write 3 when cnt=6.
      cyc(1'b1, 1'b1, 0, 10);
      wait_loaded(0);
      wait_rem(0, 7);
      cyc(1'b1, 1'b1, 0, 3);
      gap_to_tick(0, n);
      check("reprog_old_gap", 32'(n), 32'd7);
      cyc(1'b1, 1'b0, 0, 0);
      gap_to_tick(0, n);
      check("reprog_new_gap", 32'(n), 32'd3);

      // Disable ch2, then re-enable with an immediate load.
      cyc(1'b1, 1'b1, 2, 0);
      wait_loaded(2);
      idle(15);
      cyc(1'b1, 1'b1, 2, 5);
      check("pend2_dis_load", 32'(bus.pend[2]), 32'd0);
      idle(12);

      // Write on the terminal cycle, then an out-of-range channel.
      wait_rem(0, 1);
      cyc(1'b1, 1'b1, 0, 6);
      check("pend0_coinc", 32'(bus.pend[0]), 32'd0);
      cyc(1'b1, 1'b1, NCH, 7);
      check("pend_bad_ch", 32'(bus.pend), 32'd0);
      idle(14);

      // Enable gating on period 4.
      cyc(1'b1, 1'b1, 0, 4);
      wait_loaded(0);
      wait_rem(0, 2);
      for (int k = 0; k < 7; k++) cyc(1'b0, 1'b0, 0, 0);
      cyc(1'b1, 1'b0, 0, 0);
      gap_to_tick(0, n);
      check("gate_resume_gap", 32'(n), 32'd2);
      idle(12);

      // Square wave on ch1, period 3.
      cyc(1'b1, 1'b1, 1, 3);
      wait_loaded(1);
      idle(6);
      hi = 0;
      for (int k = 0; k < 12; k++) begin
         cyc(1'b1, 1'b0, 0, 0);
         if (bus.sq[1] === 1'b1) hi++;
      end
`ifdef DIVISOR_DUTY50_EN
      check("sq1_high_cycles", 32'(hi), 32'd6);
`else
      check("sq1_high_cycles", 32'(hi), 32'd0);
`endif

      // Async reset with a pending write.
      cyc(1'b1, 1'b1, 0, 9);
      async_reset();
      cyc(1'b1, 1'b0, 0, 0);
      gap_to_tick(0, n);
      check("post_rst_gap", 32'(n), 32'(DRST));

      // Random traffic.
      for (int k = 0; k < 600; k++) begin
         bit e, we;
         int ch, dv;
         e  = ($urandom_range(0, 7) != 0);
         we = ($urandom_range(0, 5) == 0);
         ch = $urandom_range(0, 3);
         dv = $urandom_range(0, 8);
         cyc(e, we, ch, dv);
         if (k == 300) async_reset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
